// File: rtl/mor1kx_dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller that drives an external simple dual-port RAM.
// Define MOR1KX_FIFO_LEVEL_FLAGS_EN to build registered almost_full/almost_empty flags.
module mor1kx_dpram_fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned AFULL_LEVEL  = 14,
    parameter int unsigned AEMPTY_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1'b1);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic                  head_valid_q, head_valid_d;
    logic [ADDR_WIDTH:0]   count_s, count_d_s;
    logic                  full_s;
    logic                  push_acc_s, pop_acc_s, re_s;

    // Occupancy includes the word parked on the RAM output register.
    assign count_s   = ram_cnt_q + {{ADDR_WIDTH{1'b0}}, head_valid_q};
    assign full_s    = (count_s == CNT_FULL);
    assign count_d_s = ram_cnt_d + {{ADDR_WIDTH{1'b0}}, head_valid_d};

    // Accept requests and schedule a head refill read.
    always_comb begin
        push_acc_s = push & ~full_s & ~flush;
        pop_acc_s  = pop & head_valid_q & ~flush;
        re_s       = (ram_cnt_q != CNT_ZERO) & (~head_valid_q | pop_acc_s) & ~flush;
    end

    // Next-state for pointers, RAM occupancy and the head-valid bit.
    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        ram_cnt_d    = ram_cnt_q;
        head_valid_d = head_valid_q;
        if (flush) begin
            wptr_d       = PTR_ZERO;
            rptr_d       = PTR_ZERO;
            ram_cnt_d    = CNT_ZERO;
            head_valid_d = 1'b0;
        end else begin
            if (push_acc_s) begin
                wptr_d = wptr_q + PTR_ONE;
            end else begin
                wptr_d = wptr_q;
            end
            if (re_s) begin
                rptr_d = rptr_q + PTR_ONE;
            end else begin
                rptr_d = rptr_q;
            end
            case ({push_acc_s, re_s})
                2'b10:   ram_cnt_d = ram_cnt_q + CNT_ONE;
                2'b01:   ram_cnt_d = ram_cnt_q - CNT_ONE;
                default: ram_cnt_d = ram_cnt_q;
            endcase
            // A refill read always lands a new head, even when the old one is popped.
            if (re_s) begin
                head_valid_d = 1'b1;
            end else if (pop_acc_s) begin
                head_valid_d = 1'b0;
            end else begin
                head_valid_d = head_valid_q;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q       <= PTR_ZERO;
            rptr_q       <= PTR_ZERO;
            ram_cnt_q    <= CNT_ZERO;
            head_valid_q <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            ram_cnt_q    <= ram_cnt_d;
            head_valid_q <= head_valid_d;
        end
    end

`ifdef MOR1KX_FIFO_LEVEL_FLAGS_EN
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);

    logic afull_q, aempty_q;

    // Level flags track the next-state count so they line up with count every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else if (flush) begin
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            afull_q  <= (count_d_s >= AFULL_C);
            aempty_q <= (count_d_s <= AEMPTY_C);
        end
    end

    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
`else
    logic unused_cnt_d_s;
    assign unused_cnt_d_s = ^count_d_s;
    assign almost_full    = 1'b0;
    assign almost_empty   = 1'b0;
`endif

    assign full      = full_s;
    assign count     = count_s;
    assign empty     = ~head_valid_q;
    assign dout      = ram_dout;
    assign ram_we    = push_acc_s;
    assign ram_waddr = wptr_q;
    assign ram_din   = din;
    assign ram_re    = re_s;
    assign ram_raddr = rptr_q;

endmodule
